inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
Instruction-side bridge sitting directly downstream of the fetch stage's inst sram interface. It accepts sram-like read requests (req / addr_ok / data_ok) from pre-IF/IF and turns them into single-beat AXI4 AR/R transactions towards the instruction memory or the cache-less AXI crossbar. It returns the fetched words in order. Up to MAX_OUTSTANDING reads can be in flight, so fetch can overlap address and data phases.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-not-returned reads (1..3)
AXI_ID, 4'd0, constant ARID driven on every read
RESET_ARADDR, 32'h1c000000, araddr value held while idle after reset

Ports:
clk  input  1  single clock, all state on rising edge
resetn  input  1  asynchronous, active-low reset
inst_sram_req  input  1  read request from pre-IF (sram-like)
inst_sram_size  input  2  transfer size, log2 bytes (fetch always 2'b10)
inst_sram_addr  input  32  request byte address
inst_sram_addr_ok  output  1  request accepted this cycle
inst_sram_data_ok  output  1  one read word returned this cycle
inst_sram_rdata  output  32  returned word, valid only with data_ok
inst_sram_err  output  1  returned word carried a non-OKAY response (valid with data_ok)
arid  output  4  = AXI_ID
araddr  output  32  read address
arlen  output  8  constant 0
arsize  output  3  {1'b0, latched size}
arburst  output  2  constant 2'b01
arlock  output  2  constant 0
arcache  output  4  constant 0
arprot  output  3  constant 0
arvalid  output  1  AR valid
arready  input  1  AR ready
rid  input  4  ignored except for sanity (single ID)
rdata  input  32  read data
rresp  input  2  read response
rlast  input  1  last beat (always 1 for arlen=0)
rvalid  input  1  R valid
rready  output  1  R ready

Behaviour:
- Reset (resetn=0, asynchronous): AR state=AR_IDLE, arvalid=0, araddr=RESET_ARADDR, latched size=2'b10, outstanding count=0. rready=0, addr_ok=0, data_ok=0. Reset mid-transaction drops all in-flight reads. R beats arriving after reset are not accepted until a new AR has been issued.
- AR FSM states: AR_IDLE and AR_SEND.
  - AR_IDLE: inst_sram_addr_ok = inst_sram_req & (cnt < MAX_OUTSTANDING). This is combinational, with no dependence on arready.
  - On addr_ok: latch addr/size into araddr/arsize, cnt+1, next state AR_SEND.
  - AR_SEND: arvalid=1 and addr_ok=0. araddr/arsize are held stable until arready. On arvalid&arready, return to AR_IDLE.
  - Throughput: at most one accepted request per 2 cycles, which is sufficient because fetch issues only when IF allowin.
- Outstanding count cnt, width 2 bits:
  - +1 on addr_ok handshake.
  - -1 on rvalid&rready&rlast.
  - Both in the same cycle: cnt unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- rready = (cnt != 0), registered-free combinational from cnt. rvalid while cnt==0 is not accepted (protocol error, left to the slave).
- Read data path is pass-through with zero latency:
  - inst_sram_data_ok = rvalid & rready.
  - inst_sram_rdata = rdata.
  - inst_sram_err = data_ok & (rresp != 2'b00).
  - Words are returned in AR-issue order; single ID, so AXI guarantees ordering.
- The bridge never discards data. Cancellation (branch/exception) is handled by the fetch stage counting and dropping data_ok beats; every accepted request produces exactly one data_ok.
- inst_sram_req deasserting while in AR_SEND has no effect; the latched request completes.
- Misaligned addresses are passed through unchanged; the fetch stage raises ADEF itself.

Test Plan:
- Reset: after resetn rises, arvalid=0, rready=0, araddr=32'h1c000000, addr_ok=0 with req=0. Assert resetn=0 while arvalid=1 and cnt=1 -> arvalid and rready drop immediately, before the next edge.
- Single fetch: req=1, addr=32'h1c000000 -> addr_ok=1 same cycle. Next cycle arvalid=1, araddr=32'h1c000000, arsize=3'b010, arlen=0. Hold arready=0 for 3 cycles -> araddr stable, addr_ok=0. After the AR handshake, drive rvalid=1, rdata=32'h02c00c0c, rlast=1 -> data_ok=1, rdata=32'h02c00c0c, err=0, then rready=0.
- Pipelined: two requests 0x1c000000 and 0x1c000004 accepted before any R beat -> cnt=2. A third req is held with addr_ok=0 until the first R beat. R beats return in order, giving data_ok twice and cnt back to 0.
- Simultaneous: addr_ok for 0x1c000008 in the same cycle as the R handshake for 0x1c000004 -> cnt unchanged at 1, no lost or duplicate data_ok.
- Error response: rresp=2'b10 on return -> data_ok=1 with inst_sram_err=1, cnt decrements normally.
- Stray R: rvalid=1 with cnt=0 -> rready=0, data_ok=0, no state change.

Source files
------------

// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for the instruction read bridge: the sram-like fetch side
// and the single-beat AXI4 read channel (AR/R) toward instruction memory.
interface inst_sram_if;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, size, addr, input addr_ok, data_ok, rdata, err);
  modport slave  (input req, size, addr, output addr_ok, data_ok, rdata, err);
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
                  arvalid, rready,
                  input arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
                  arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side sram-like to AXI4 read bridge: one AR per accepted request,
// up to MAX_OUTSTANDING reads in flight, R data passed straight through in order.
module inst_axi_rd_bridge #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'd0,
  parameter logic [31:0] RESET_ARADDR    = 32'h1c000000
) (
  input  logic      clk,
  input  logic      resetn,
  inst_sram_if.slave sram,
  axi_rd_if.master   axi
);

  typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;

  ar_state_t   state, state_nxt;
  logic [1:0]  cnt;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        addr_ok, arvalid, rready, r_done;

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    arvalid   = 1'b0;
    case (state)
      AR_IDLE: begin
        // acceptance deliberately ignores arready so fetch sees a stable handshake
        addr_ok = sram.req && (cnt < 2'(MAX_OUTSTANDING));
        if (addr_ok) state_nxt = AR_SEND;
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (axi.arready) state_nxt = AR_IDLE;
      end
      default: state_nxt = AR_IDLE;
    endcase
  end

  assign rready = (cnt != 2'd0);
  assign r_done = axi.rvalid && rready && axi.rlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= AR_IDLE;
      addr_q <= RESET_ARADDR;
      size_q <= 2'b10;
      cnt    <= 2'd0;
    end else begin
      state <= state_nxt;
      if (addr_ok) begin
        addr_q <= sram.addr;
        size_q <= sram.size;
      end
      case ({addr_ok, r_done})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign sram.addr_ok = addr_ok;
  assign sram.data_ok = axi.rvalid && rready;
  assign sram.rdata   = axi.rdata;
  assign sram.err     = axi.rvalid && rready && (axi.rresp != 2'b00);

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  // single-ID bridge: any accepted beat must carry our ID
  a_rid: assert property (@(posedge clk) disable iff (!resetn)
    (axi.rvalid && rready) |-> (axi.rid == AXI_ID));

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: table of single fetches, directed multi-cycle
// sequences, then random traffic checked against a queue-based model.
module tb_inst_axi_rd_bridge;
  localparam int MAX = 2;
  localparam logic [31:0] RST_ADDR = 32'h1c000000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_sram_if sram();
  axi_rd_if    axi();

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'd0), .RESET_ARADDR(RST_ADDR)) dut (
    .clk(clk), .resetn(resetn), .sram(sram), .axi(axi));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          ar_wait;
    logic        hold_req;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
  } req_t;

  req_t ar_q[$];
  req_t r_q[$];

  task automatic do_vec(input vec_t v);
    @(negedge clk);
    sram.req = 1'b1; sram.addr = v.addr; sram.size = 2'b10;
    #1 chk("vec addr_ok", sram.addr_ok, 1);
    @(negedge clk);
    sram.req = v.hold_req; sram.addr = v.addr + 32'h40;
    #1;
    chk("vec arvalid", axi.arvalid, 1);
    chk("vec araddr", axi.araddr, v.addr);
    chk("vec arsize", axi.arsize, 3'b010);
    chk("vec arlen", axi.arlen, 0);
    chk("vec addr_ok busy", sram.addr_ok, 0);
    for (int i = 0; i < v.ar_wait; i++) begin
      @(negedge clk);
      #1;
      chk("vec araddr hold", axi.araddr, v.addr);
      chk("vec arvalid hold", axi.arvalid, 1);
      chk("vec addr_ok hold", sram.addr_ok, 0);
    end
    @(negedge clk);
    axi.arready = 1'b1; sram.req = 1'b0;
    #1 chk("vec arvalid hs", axi.arvalid, 1);
    @(negedge clk);
    axi.arready = 1'b0;
    #1;
    chk("vec arvalid done", axi.arvalid, 0);
    chk("vec rready", axi.rready, 1);
    @(negedge clk);
    axi.rvalid = 1'b1; axi.rdata = v.data; axi.rresp = v.resp; axi.rlast = 1'b1;
    #1;
    chk("vec data_ok", sram.data_ok, 1);
    chk("vec rdata", sram.rdata, v.data);
    chk("vec err", sram.err, v.exp_err);
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    chk("vec rready idle", axi.rready, 0);
    chk("vec data_ok idle", sram.data_ok, 0);
  endtask

  task automatic rand_cycle(input bit busy);
    req_t nr;
    logic rv;
    logic [31:0] rd;
    logic [1:0] rr;
    logic exp_ok;
    int outst;
    @(negedge clk);
    nr.a = $urandom;
    nr.s = 2'($urandom_range(0, 2));
    sram.req = busy && ($urandom_range(0, 2) != 0);
    sram.addr = nr.a; sram.size = nr.s;
    axi.arready = busy ? ($urandom_range(0, 2) != 0) : 1'b1;
    rv = (r_q.size() != 0) && (!busy || ($urandom_range(0, 1) == 1));
    if (rv) begin
      rd = r_q[0].a ^ 32'h5a5aa5a5;
      rr = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
    end else begin
      rd = $urandom;
      rr = 2'b00;
    end
    axi.rvalid = rv; axi.rdata = rd; axi.rresp = rr; axi.rlast = 1'b1;
    #1;
    outst = ar_q.size() + r_q.size();
    exp_ok = sram.req && (ar_q.size() == 0) && (outst < MAX);
    chk("rnd addr_ok", sram.addr_ok, exp_ok);
    chk("rnd arvalid", axi.arvalid, ar_q.size() != 0);
    chk("rnd rready", axi.rready, outst != 0);
    chk("rnd data_ok", sram.data_ok, rv);
    if (ar_q.size() != 0) begin
      chk("rnd araddr", axi.araddr, ar_q[0].a);
      chk("rnd arsize", axi.arsize, {1'b0, ar_q[0].s});
    end
    if (rv) begin
      chk("rnd rdata", sram.rdata, rd);
      chk("rnd err", sram.err, rr != 2'b00);
      void'(r_q.pop_front());
    end
    if (ar_q.size() != 0 && axi.arready) r_q.push_back(ar_q.pop_front());
    if (exp_ok) ar_q.push_back(nr);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{32'h1c000000, 32'h02c00c0c, 2'b00, 3, 1'b1, 1'b0};
    vt[1] = '{32'h1c000004, 32'hdeadbeef, 2'b10, 0, 1'b0, 1'b1};
    vt[2] = '{32'h1c000003, 32'h12345678, 2'b11, 1, 1'b1, 1'b1};
    vt[3] = '{32'h00000ffc, 32'hcafef00d, 2'b01, 2, 1'b0, 1'b1};

    sram.req = 0; sram.size = 2'b10; sram.addr = 0;
    axi.arready = 0; axi.rid = 4'd0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;

    // reset state
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst arvalid", axi.arvalid, 0);
    chk("rst rready", axi.rready, 0);
    chk("rst araddr", axi.araddr, RST_ADDR);
    chk("rst addr_ok", sram.addr_ok, 0);
    chk("rst data_ok", sram.data_ok, 0);
    chk("rst arsize", axi.arsize, 3'b010);
    chk("const arid", axi.arid, 0);
    chk("const arburst", axi.arburst, 2'b01);

    foreach (vt[i]) do_vec(vt[i]);

    // pipelined: two in flight, third held until first return
    @(negedge clk); sram.req = 1; sram.addr = 32'h1c000000;
    #1 chk("pipe ok0", sram.addr_ok, 1);
    @(negedge clk); sram.req = 0; axi.arready = 1;
    #1 chk("pipe ar0", axi.araddr, 32'h1c000000);
    @(negedge clk); axi.arready = 0; sram.req = 1; sram.addr = 32'h1c000004;
    #1 chk("pipe ok1", sram.addr_ok, 1);
    @(negedge clk); sram.req = 0; axi.arready = 1;
    #1 chk("pipe ar1", axi.araddr, 32'h1c000004);
    @(negedge clk); axi.arready = 0; sram.req = 1; sram.addr = 32'h1c000008;
    #1 chk("pipe full", sram.addr_ok, 0);
    @(negedge clk);
    #1 chk("pipe full2", sram.addr_ok, 0);
    @(negedge clk); axi.rvalid = 1; axi.rdata = 32'h11110000; axi.rresp = 0; axi.rlast = 1;
    #1;
    chk("pipe full3", sram.addr_ok, 0);
    chk("pipe d0 ok", sram.data_ok, 1);
    chk("pipe d0", sram.rdata, 32'h11110000);
    @(negedge clk); axi.rvalid = 0;
    #1 chk("pipe ok2", sram.addr_ok, 1);
    @(negedge clk); sram.req = 0; axi.arready = 1;
    #1 chk("pipe ar2", axi.araddr, 32'h1c000008);
    @(negedge clk); axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h22220004;
    #1 chk("pipe d1", sram.rdata, 32'h22220004);
    @(negedge clk); axi.rdata = 32'h33330008;
    #1;
    chk("pipe d2 ok", sram.data_ok, 1);
    chk("pipe d2", sram.rdata, 32'h33330008);
    @(negedge clk); axi.rvalid = 0;
    #1 chk("pipe drained", axi.rready, 0);

    // accept and return in the same cycle
    @(negedge clk); sram.req = 1; sram.addr = 32'h1c000004;
    #1 chk("sim ok0", sram.addr_ok, 1);
    @(negedge clk); sram.req = 0; axi.arready = 1;
    @(negedge clk); axi.arready = 0; sram.req = 1; sram.addr = 32'h1c000008;
    axi.rvalid = 1; axi.rdata = 32'h44440004;
    #1;
    chk("sim ok1", sram.addr_ok, 1);
    chk("sim data_ok", sram.data_ok, 1);
    @(negedge clk); sram.req = 0; axi.rvalid = 0; axi.arready = 1;
    #1;
    chk("sim cnt1", axi.rready, 1);
    chk("sim ar", axi.araddr, 32'h1c000008);
    chk("sim no dup", sram.data_ok, 0);
    @(negedge clk); axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h55550008;
    #1 chk("sim d1", sram.rdata, 32'h55550008);
    @(negedge clk); axi.rvalid = 0;
    #1 chk("sim drained", axi.rready, 0);

    // stray R with nothing outstanding
    @(negedge clk); axi.rvalid = 1; axi.rdata = 32'hbad0bad0; axi.rresp = 2'b10;
    #1;
    chk("stray rready", axi.rready, 0);
    chk("stray data_ok", sram.data_ok, 0);
    chk("stray err", sram.err, 0);
    @(negedge clk); axi.rvalid = 0;
    #1 chk("stray arvalid", axi.arvalid, 0);

    // async reset while AR pending with one outstanding
    @(negedge clk); sram.req = 1; sram.addr = 32'h1c000010;
    @(negedge clk); sram.req = 0;
    #1;
    chk("ar pend", axi.arvalid, 1);
    chk("ar pend rready", axi.rready, 1);
    resetn = 0;
    #1;
    chk("async arvalid", axi.arvalid, 0);
    chk("async rready", axi.rready, 0);
    chk("async araddr", axi.araddr, RST_ADDR);
    @(negedge clk); resetn = 1; axi.rvalid = 1; axi.rdata = 32'h0;
    #1;
    chk("post rst rready", axi.rready, 0);
    chk("post rst data_ok", sram.data_ok, 0);
    @(negedge clk); axi.rvalid = 0;

    // random traffic against the queue model, then drain
    ar_q.delete(); r_q.delete();
    for (int i = 0; i < 2000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 40 && (ar_q.size() + r_q.size()) != 0; i++) rand_cycle(1'b0);
    chk("drain outstanding", ar_q.size() + r_q.size(), 0);
    @(negedge clk); axi.rvalid = 0; sram.req = 0;
    #1 chk("final rready", axi.rready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
